// File: rtl/io_bus_pkg.sv
// Shared types for the io bus arbiter: FSM states, master index and default timeout.
// Also holds a small index-to-one-hot helper used by the arbiter and its picker.
package io_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef logic mst_idx_t;

   localparam int TIMEOUT_DEF = 16;

   function automatic logic [1:0] mst_oh(mst_idx_t idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Master-side request/response signals plus the io bus, bundled for io_bus_arbiter.
// slave = arbiter view; master = requesters and io device view.
interface io_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [1:0]          m_req;
   logic [1:0]          m_we;
   logic [2*ADDR_W-1:0] m_addr;
   logic [2*DATA_W-1:0] m_wdata;
   logic [1:0]          m_gnt;
   logic [1:0]          m_done;
   logic [DATA_W-1:0]   m_rdata;
   logic [1:0]          m_err;
   logic [ADDR_W-1:0]   io_address;
   logic [DATA_W-1:0]   io_write_value;
   logic [DATA_W-1:0]   io_read_value;
   logic                io_write_en;
   logic                io_read_en;
   logic                io_ready;

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, io_read_value, io_ready,
      output m_gnt, m_done, m_rdata, m_err, io_address, io_write_value,
             io_write_en, io_read_en
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata, io_read_value, io_ready,
      input  m_gnt, m_done, m_rdata, m_err, io_address, io_write_value,
             io_write_en, io_read_en
   );
endinterface

// File: rtl/io_arb_rr.sv
// Two-way round-robin pick: a lone requester wins; on a tie the master not
// served last wins. Output is one-hot (or zero with no request).
module io_arb_rr
   import io_bus_pkg::*;
(
   input  logic [1:0] req,
   input  mst_idx_t   last,
   output logic [1:0] win
);
   always_comb begin
      win = req;
      if (&req) win = mst_oh(~last);
   end
endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master io bus arbiter: IDLE -> ACCESS -> RESP, one transfer at a time.
// Optional ACCESS timeout abort when IO_ARB_TIMEOUT_EN is defined.
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic          clk,
   input logic          rst_n,
   io_bus_arbiter_if.slave bus
);
   arb_state_e        state_q, state_d;
   mst_idx_t          last_q, cur_q, win_idx;
   logic              first_q, we_q, timeout_hit;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic [1:0]        win;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("io_bus_arbiter: TIMEOUT must be at least 1");
   end

   io_arb_rr u_rr (.req(bus.m_req), .last(last_q), .win(win));
   assign win_idx = win[1];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|bus.m_req) state_d = ACCESS;
         ACCESS:  if (bus.io_ready || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // last_q resets to master 1 so master 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cur_q   <= 1'b0;
         first_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         first_q <= (state_q == IDLE) && (state_d == ACCESS);
         case (state_q)
            IDLE: if (|bus.m_req) begin
               cur_q   <= win_idx;
               we_q    <= bus.m_we[win_idx];
               addr_q  <= win_idx ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0];
               wdata_q <= win_idx ? bus.m_wdata[2*DATA_W-1:DATA_W] : bus.m_wdata[DATA_W-1:0];
            end
            ACCESS: begin
               if (bus.io_ready) begin
                  if (!we_q) rdata_q <= bus.io_read_value;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
               end
            end
            RESP:    last_q <= cur_q;
            default: ;
         endcase
      end
   end

`ifdef IO_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   // limit cycle with io_ready completes normally; ready has priority in ACCESS
   assign timeout_hit = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (state_q == IDLE) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (state_q == ACCESS) begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (!bus.io_ready && timeout_hit) err_q <= 1'b1;
      end
   end

   assign bus.m_err = (state_q == RESP && err_q) ? mst_oh(cur_q) : 2'b00;
`else
   assign timeout_hit = 1'b0;
   assign bus.m_err   = 2'b00;
`endif

   assign bus.m_gnt          = (state_q == ACCESS && first_q) ? mst_oh(cur_q) : 2'b00;
   assign bus.m_done         = (state_q == RESP) ? mst_oh(cur_q) : 2'b00;
   assign bus.m_rdata        = rdata_q;
   assign bus.io_address     = (state_q == ACCESS) ? addr_q  : '0;
   assign bus.io_write_value = (state_q == ACCESS) ? wdata_q : '0;
   assign bus.io_write_en    = (state_q == ACCESS) &&  we_q;
   assign bus.io_read_en     = (state_q == ACCESS) && !we_q;

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 32, io/master address width.
- REQ-002: Parameter DATA_W, default 32, io/master data width.
- REQ-003: Parameter TIMEOUT, default 16, ACCESS-cycle limit before abort; only used with IO_ARB_TIMEOUT_EN.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006: m_req  input  2  per-master request; bit i = master i (0 = CPU, 1 = DMA/debug).
- REQ-007: m_we  input  2  per-master 1 = write, 0 = read.
- REQ-008: m_addr  input  2*ADDR_W  per-master address; master i in slice [i*ADDR_W +: ADDR_W].
- REQ-009: m_wdata  input  2*DATA_W  per-master write data; same slicing as m_addr.
- REQ-010: m_gnt  output  2  one-cycle pulse; request of master i captured.
- REQ-011: m_done  output  2  one-cycle pulse; transaction of master i complete.
- REQ-012: m_rdata  output  DATA_W  read data, valid only while m_done is high.
- REQ-013: m_err  output  2  high with m_done when the transaction aborted.
- REQ-014: io_address  output  ADDR_W  io bus address.
- REQ-015: io_write_value  output  DATA_W  io bus write data.
- REQ-016: io_read_value  input  DATA_W  io bus read data, sampled when io_ready is high.
- REQ-017: io_write_en / io_read_en  output  1 each  io bus strobes; never both high.
- REQ-018: io_ready  input  1  slave completes current access this cycle.

Function
- REQ-019: FSM states IDLE, ACCESS, RESP; the arbiter samples m_req only in IDLE.
- REQ-020: In IDLE with any m_req bit set, the arbiter latches the winner's addr, wdata and we into registers and moves to ACCESS.
- REQ-021: Arbitration is round-robin: with both requesting, the master not last served wins; after reset master 0 is preferred.
- REQ-022: m_gnt[i] is high exactly during the first ACCESS cycle.
- REQ-023: In ACCESS, io_address and io_write_value are driven from the latched registers; io_write_en = we, io_read_en = ~we, held until io_ready.
- REQ-024: io_ready high in ACCESS: on reads, io_read_value is captured into m_rdata; FSM moves to RESP; strobes low from the next cycle.
- REQ-025: In RESP, m_done[i] pulses for one cycle, the last-served pointer updates to i, and the FSM returns to IDLE.
- REQ-026: Latency: req sampled at cycle N, gnt and strobes at N+1, done at K+1 where K is the first io_ready cycle (minimum N+2).
- REQ-027: A master holding m_req through RESP is re-arbitrated in the following IDLE (back-to-back allowed); m_req must be deasserted at or before m_done if no further transfer is wanted.
- REQ-028: io_ready in IDLE or RESP is ignored; m_rdata holds its last value outside RESP.
- REQ-029: Address and data outputs are zero in IDLE.

Reset
- REQ-030: rst_n low immediately forces state IDLE and clears all outputs, m_rdata, the latched registers, the timeout counter and the pointer (master 0 preferred), including mid-ACCESS.
- REQ-031: First arbitration occurs at the first rising edge after rst_n deasserts.

Configuration
- REQ-032: Macro IO_ARB_TIMEOUT_EN defined: an ACCESS-cycle counter aborts after TIMEOUT cycles without io_ready, goes to RESP with m_err[i] = 1 and m_rdata = 0; io_ready on the limit cycle wins, with no error.
- REQ-033: Macro IO_ARB_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, m_err tied to 0.

Structure
- REQ-034: Package io_bus_pkg holds the state enum (IDLE/ACCESS/RESP), the master-index typedef and the default-TIMEOUT constant.
- REQ-035: Sub-module io_arb_rr implements the 2-way round-robin pick (inputs req and last pointer, output one-hot winner).

Verification
- REQ-036: m0 read addr 0x100, req at N, io_ready at N+3 with 0xDEADBEEF -> m_gnt[0] at N+1, io_read_en high N+1..N+3, m_done[0] and m_rdata = 0xDEADBEEF at N+4.
- REQ-037: m1 write addr 0x2000 data 0x12345678, io_ready held high -> io_write_en high only at N+1, m_done[1] at N+2, io_read_en never high.
- REQ-038: Both m_req held high after reset, io_ready = 1 -> grant order 0, 1, 0, 1, with one transaction per 3 cycles.
- REQ-039: IO_ARB_TIMEOUT_EN defined, TIMEOUT = 4, io_ready = 0 -> strobes drop after 4 ACCESS cycles, m_done[0] with m_err[0] = 1 and m_rdata = 0; macro undefined -> strobes still high after 100 cycles.
- REQ-040: rst_n low mid-ACCESS -> strobes and m_gnt/m_done low in the same cycle; after release, both masters requesting -> m0 granted first.
